// File: rtl/cd_csr_host_if.sv
// CSR bus between cd_csr_host (master) and the cdbus controller register file (slave).
// Read data is combinational from the slave and is valid while csr_read is high.
interface cd_csr_host_if;
    logic [3:0]  csr_address;
    logic        csr_read;
    logic [31:0] csr_readdata;
    logic        csr_write;
    logic [31:0] csr_writedata;

    modport master (
        output csr_address,
        output csr_read,
        output csr_write,
        output csr_writedata,
        input  csr_readdata
    );

    modport slave (
        input  csr_address,
        input  csr_read,
        input  csr_write,
        input  csr_writedata,
        output csr_readdata
    );
endinterface

// File: rtl/cd_csr_host.sv
// Autonomous CSR initiator for the cdbus controller: configures it after reset, drains RX frames
// into a byte stream on irq, and packs a TX byte stream into TX RAM words before switching the page.
module cd_csr_host #(
    parameter logic [7:0] SETTING   = 8'h10,
    parameter logic [7:0] FILTER    = 8'hff,
    parameter logic [7:0] INT_MASK  = 8'h02,
    parameter int         HDR_BYTES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 irq,
    cd_csr_host_if.master        csr,
    input  logic [7:0]           tx_data,
    input  logic                 tx_valid,
    input  logic                 tx_last,
    output logic                 tx_ready,
    output logic [7:0]           rx_data,
    output logic                 rx_valid,
    output logic                 rx_last,
    input  logic                 rx_ready,
    output logic [7:0]           flag_last,
    output logic                 tx_overflow
);

    localparam logic [3:0] REG_SETTING  = 4'h1;
    localparam logic [3:0] REG_FILTER   = 4'h6;
    localparam logic [3:0] REG_INT_MASK = 4'h9;
    localparam logic [3:0] REG_INT_FLAG = 4'ha;
    localparam logic [3:0] REG_RX       = 4'hb;
    localparam logic [3:0] REG_TX       = 4'hc;
    localparam logic [3:0] REG_RX_CTRL  = 4'hd;
    localparam logic [3:0] REG_TX_CTRL  = 4'he;

    typedef enum logic [3:0] {
        INIT_SET,
        INIT_FILT,
        INIT_MASK,
        IDLE,
        RX_FLAG,
        RX_CLR,
        RX_RD,
        RX_OUT,
        RX_DONE,
        TX_CLR,
        TX_COLLECT,
        TX_WR,
        TX_POLL,
        TX_SW
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [8:0]  byte_idx;
    logic [1:0]  lane;
    logic [8:0]  nbytes;
    logic [31:0] word;
    logic        tx_last_seen;
    logic        ovf_seen;

    logic [3:0]  addr_q;
    logic        rd_q;
    logic        wr_q;
    logic [31:0] wdata_q;

    logic [3:0]  addr_nxt;
    logic        rd_nxt;
    logic        wr_nxt;
    logic [31:0] wdata_nxt;

    logic [31:0] word_merged;
    logic [9:0]  hdr_sum;
    logic [8:0]  nbytes_calc;
    logic        rx_hs;
    logic        tx_hs;
    logic        rx_byte_last;

    assign tx_ready     = (state == TX_COLLECT);
    assign rx_valid     = (state == RX_OUT);
    assign rx_byte_last = (byte_idx == nbytes - 9'd1);
    assign rx_last      = rx_valid && rx_byte_last;
    assign rx_data      = rx_valid ? word[{lane, 3'b000} +: 8] : 8'h00;
    assign rx_hs        = rx_valid && rx_ready;
    assign tx_hs        = tx_valid && tx_ready;

    assign csr.csr_address   = addr_q;
    assign csr.csr_read      = rd_q;
    assign csr.csr_write     = wr_q;
    assign csr.csr_writedata = wdata_q;

    // Word with the incoming TX byte placed in its lane; also the data of the TX RAM write.
    always_comb begin
        word_merged = word;
        word_merged[{lane, 3'b000} +: 8] = tx_data;
        hdr_sum     = {2'b00, csr.csr_readdata[15:8]} + 10'(HDR_BYTES);
        nbytes_calc = (hdr_sum > 10'd256) ? 9'd256 : hdr_sum[8:0];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT_SET:   state_nxt = INIT_FILT;
            INIT_FILT:  state_nxt = INIT_MASK;
            INIT_MASK:  state_nxt = IDLE;
            IDLE: begin
                if (irq)
                    state_nxt = RX_FLAG;
                else if (tx_valid)
                    state_nxt = TX_CLR;
            end
            RX_FLAG:    state_nxt = csr.csr_readdata[1] ? RX_CLR : IDLE;
            RX_CLR:     state_nxt = RX_RD;
            RX_RD:      state_nxt = RX_OUT;
            RX_OUT: begin
                if (rx_hs) begin
                    if (rx_byte_last)
                        state_nxt = RX_DONE;
                    else if (lane == 2'd3)
                        state_nxt = RX_RD;
                end
            end
            RX_DONE:    state_nxt = IDLE;
            TX_CLR:     state_nxt = TX_COLLECT;
            TX_COLLECT: begin
                if (tx_hs) begin
                    if (!byte_idx[8]) begin
                        if (tx_last || lane == 2'd3)
                            state_nxt = TX_WR;
                    end else if (tx_last) begin
                        state_nxt = TX_POLL;
                    end
                end
            end
            TX_WR:      state_nxt = tx_last_seen ? TX_POLL : TX_COLLECT;
            TX_POLL:    state_nxt = csr.csr_readdata[5] ? TX_SW : TX_POLL;
            TX_SW:      state_nxt = IDLE;
            default:    state_nxt = INIT_SET;
        endcase
    end

    // Init writes are issued by the init states themselves so the first access follows reset by one
    // cycle; every other access is decoded from the state being entered and is live during that state.
    always_comb begin
        addr_nxt  = 4'h0;
        rd_nxt    = 1'b0;
        wr_nxt    = 1'b0;
        wdata_nxt = 32'h0;
        case (state)
            INIT_SET: begin
                wr_nxt    = 1'b1;
                addr_nxt  = REG_SETTING;
                wdata_nxt = {24'h0, SETTING};
            end
            INIT_FILT: begin
                wr_nxt    = 1'b1;
                addr_nxt  = REG_FILTER;
                wdata_nxt = {24'h0, FILTER};
            end
            INIT_MASK: begin
                wr_nxt    = 1'b1;
                addr_nxt  = REG_INT_MASK;
                wdata_nxt = {24'h0, INT_MASK};
            end
            default: begin
                case (state_nxt)
                    RX_FLAG, TX_POLL: begin
                        rd_nxt   = 1'b1;
                        addr_nxt = REG_INT_FLAG;
                    end
                    RX_CLR: begin
                        wr_nxt   = 1'b1;
                        addr_nxt = REG_RX_CTRL;
                    end
                    RX_RD: begin
                        rd_nxt   = 1'b1;
                        addr_nxt = REG_RX;
                    end
                    RX_DONE: begin
                        wr_nxt    = 1'b1;
                        addr_nxt  = REG_RX_CTRL;
                        wdata_nxt = 32'h2;
                    end
                    TX_CLR: begin
                        wr_nxt   = 1'b1;
                        addr_nxt = REG_TX_CTRL;
                    end
                    TX_WR: begin
                        wr_nxt    = 1'b1;
                        addr_nxt  = REG_TX;
                        wdata_nxt = word_merged;
                    end
                    TX_SW: begin
                        wr_nxt    = 1'b1;
                        addr_nxt  = REG_TX_CTRL;
                        wdata_nxt = 32'h2;
                    end
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= INIT_SET;
            byte_idx     <= 9'd0;
            lane         <= 2'd0;
            nbytes       <= 9'd0;
            word         <= 32'h0;
            tx_last_seen <= 1'b0;
            ovf_seen     <= 1'b0;
            flag_last    <= 8'h00;
            tx_overflow  <= 1'b0;
            addr_q       <= 4'h0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            wdata_q      <= 32'h0;
        end else begin
            state       <= state_nxt;
            addr_q      <= addr_nxt;
            rd_q        <= rd_nxt;
            wr_q        <= wr_nxt;
            wdata_q     <= wdata_nxt;
            tx_overflow <= 1'b0;
            case (state)
                RX_FLAG: begin
                    flag_last <= csr.csr_readdata[7:0];
                    nbytes    <= nbytes_calc;
                    byte_idx  <= 9'd0;
                end
                RX_RD: begin
                    word <= csr.csr_readdata;
                    lane <= 2'd0;
                end
                RX_OUT: begin
                    if (rx_hs) begin
                        byte_idx <= byte_idx + 9'd1;
                        lane     <= lane + 2'd1;
                    end
                end
                TX_CLR: begin
                    byte_idx     <= 9'd0;
                    lane         <= 2'd0;
                    word         <= 32'h0;
                    tx_last_seen <= 1'b0;
                    ovf_seen     <= 1'b0;
                end
                // Bytes past 256 are accepted and dropped; the word is cleared once handed to TX_WR.
                TX_COLLECT: begin
                    if (tx_hs) begin
                        if (!byte_idx[8]) begin
                            word         <= (tx_last || lane == 2'd3) ? 32'h0 : word_merged;
                            lane         <= lane + 2'd1;
                            byte_idx     <= byte_idx + 9'd1;
                            tx_last_seen <= tx_last;
                        end else if (!ovf_seen) begin
                            tx_overflow <= 1'b1;
                            ovf_seen    <= 1'b1;
                        end
                    end
                end
                TX_POLL: flag_last <= csr.csr_readdata[7:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cd_csr_host.sv
// Directed bench for cd_csr_host: a small register-file model answers the CSR bus, a monitor logs
// every access and RX byte, and the main sequence compares them against hand-computed values.
module tb_cd_csr_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_last;
    logic        rx_ready;
    logic [7:0]  flag_last;
    logic        tx_overflow;

    cd_csr_host_if bus ();

    cd_csr_host dut (
        .clk         (clk),
        .reset       (reset),
        .irq         (irq),
        .csr         (bus.master),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_last     (tx_last),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_last     (rx_last),
        .rx_ready    (rx_ready),
        .flag_last   (flag_last),
        .tx_overflow (tx_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        int          cyc;
    } acc_t;

    acc_t        log_q[$];
    logic [8:0]  rx_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          a_reads = 0;
    int          rx_rd_ptr = 0;
    int          free_after = 1000000;
    int          both_cnt = 0;
    int          stall_err = 0;
    int          ovf_cnt = 0;
    logic [31:0] int_flag;
    logic [31:0] rx_ram [0:15];
    logic        hold_pending = 1'b0;
    logic [8:0]  held;

    // Register-file model: INT_FLAG reports tx-buffer-free once free_after reads have happened.
    always_comb begin
        bus.csr_readdata = 32'h0;
        if (bus.csr_read) begin
            if (bus.csr_address == 4'ha)
                bus.csr_readdata = int_flag | ((a_reads >= free_after) ? 32'h20 : 32'h0);
            else if (bus.csr_address == 4'hb)
                bus.csr_readdata = rx_ram[rx_rd_ptr[3:0]];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.csr_read && bus.csr_address == 4'ha)
            a_reads <= a_reads + 1;
        if (bus.csr_read && bus.csr_address == 4'hb)
            rx_rd_ptr <= rx_rd_ptr + 1;
        if (bus.csr_write && bus.csr_address == 4'hd && bus.csr_writedata == 32'h0)
            rx_rd_ptr <= 0;
    end

    always @(negedge clk) begin
        if (!reset && (bus.csr_read || bus.csr_write))
            log_q.push_back('{bus.csr_write, bus.csr_address,
                              bus.csr_write ? bus.csr_writedata : bus.csr_readdata, cyc});
        if (bus.csr_read && bus.csr_write)
            both_cnt++;
        if (tx_overflow)
            ovf_cnt++;
        if (rx_valid && rx_ready)
            rx_q.push_back({rx_last, rx_data});
        if (hold_pending && rx_valid && {rx_last, rx_data} !== held)
            stall_err++;
        hold_pending = rx_valid && !rx_ready;
        held = {rx_last, rx_data};
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAccess(input int idx, input logic wr, input logic [3:0] addr,
                               input logic [31:0] data, input string tag);
        logic [36:0] obs;
        obs = 'x;
        if (idx < log_q.size())
            obs = {log_q[idx].wr, log_q[idx].addr, log_q[idx].data};
        checkOutput(tag, {27'h0, obs}, {27'h0, wr, addr, data});
    endtask

    task automatic checkByte(input int idx, input logic [7:0] data, input logic last, input string tag);
        logic [8:0] obs;
        obs = 'x;
        if (idx < rx_q.size())
            obs = rx_q[idx];
        checkOutput(tag, {55'h0, obs}, {55'h0, last, data});
    endtask

    task automatic checkInit(input int base, input string tag);
        int span;
        checkOutput({tag, "_count"}, 64'(log_q.size() - base), 64'd3);
        checkAccess(base,     1'b1, 4'h1, 32'h10, {tag, "_setting"});
        checkAccess(base + 1, 1'b1, 4'h6, 32'hff, {tag, "_filter"});
        checkAccess(base + 2, 1'b1, 4'h9, 32'h02, {tag, "_mask"});
        span = -1;
        if (log_q.size() >= base + 3)
            span = log_q[base + 2].cyc - log_q[base].cyc;
        checkOutput({tag, "_consecutive"}, 64'(span), 64'd2);
    endtask

    task automatic waitForAccess(input int base, input logic wr, input logic [3:0] addr,
                                 input logic [31:0] data, input int budget, input string tag);
        bit found;
        found = 1'b0;
        for (int c = 0; c < budget && !found; c++) begin
            @(posedge clk);
            #1;
            for (int i = base; i < log_q.size(); i++)
                if (log_q[i].wr == wr && log_q[i].addr == addr && log_q[i].data == data)
                    found = 1'b1;
        end
        checkOutput(tag, {63'h0, found}, 64'd1);
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic last, input string tag);
        bit ok;
        ok       = 1'b0;
        tx_data  = b;
        tx_valid = 1'b1;
        tx_last  = last;
        for (int c = 0; c < 20; c++) begin
            if (tx_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput(tag, {63'h0, ok}, 64'd1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
    endtask

    task automatic pulseIrq();
        irq = 1'b1;
        @(posedge clk);
        #1;
        irq = 1'b0;
    endtask

    initial begin
        int          base;
        int          rbase;
        int          obase;
        int          nc;
        bit          found;
        logic [31:0] first_w;
        logic [31:0] last_w;

        reset    = 1'b1;
        irq      = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        rx_ready = 1'b1;
        int_flag = 32'h0;
        for (int i = 0; i < 16; i++)
            rx_ram[i] = 32'h0;

        // Reset state and init sequence
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
                    {6'h0, bus.csr_read, bus.csr_write, bus.csr_address, bus.csr_writedata, tx_ready,
                     rx_valid, rx_last, rx_data, flag_last, tx_overflow}, 64'h0);
        base  = log_q.size();
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkInit(base, "init");

        // RX: length 5 + 3 header bytes = 8 bytes in two words
        $display("[TB] RX frame of 8 bytes");
        int_flag  = 32'h0502;
        rx_ram[0] = 32'h44332211;
        rx_ram[1] = 32'h88776655;
        base      = log_q.size();
        rbase     = rx_q.size();
        pulseIrq();
        waitForAccess(base, 1'b1, 4'hd, 32'h2, 200, "rx_done_seen");
        checkOutput("rx_log_count", 64'(log_q.size() - base), 64'd5);
        checkAccess(base,     1'b0, 4'ha, 32'h0502,     "rx_flag_read");
        checkAccess(base + 1, 1'b1, 4'hd, 32'h0,        "rx_clr_write");
        checkAccess(base + 2, 1'b0, 4'hb, 32'h44332211, "rx_word0_read");
        checkAccess(base + 3, 1'b0, 4'hb, 32'h88776655, "rx_word1_read");
        checkAccess(base + 4, 1'b1, 4'hd, 32'h2,        "rx_release");
        checkOutput("rx_byte_count", 64'(rx_q.size() - rbase), 64'd8);
        for (int k = 0; k < 8; k++)
            checkByte(rbase + k, 8'(8'h11 * (k + 1)), k == 7, $sformatf("rx_byte%0d", k));
        checkOutput("rx_flag_last", {56'h0, flag_last}, 64'h02);

        // irq without rx_pending: one INT_FLAG read and nothing else
        int_flag = 32'h0001;
        base     = log_q.size();
        rbase    = rx_q.size();
        pulseIrq();
        repeat (6) @(posedge clk);
        #1;
        checkOutput("nopend_count", 64'(log_q.size() - base), 64'd1);
        checkAccess(base, 1'b0, 4'ha, 32'h0001, "nopend_read");
        checkOutput("nopend_flag_last", {56'h0, flag_last}, 64'h01);
        checkOutput("nopend_no_bytes", 64'(rx_q.size() - rbase), 64'd0);

        // RX with rx_ready toggling: 9 + 3 = 12 bytes
        $display("[TB] RX frame of 12 bytes with stalls");
        int_flag  = 32'h0902;
        rx_ram[0] = 32'ha3a2a1a0;
        rx_ram[1] = 32'ha7a6a5a4;
        rx_ram[2] = 32'habaaa9a8;
        base      = log_q.size();
        rbase     = rx_q.size();
        pulseIrq();
        found = 1'b0;
        for (int c = 0; c < 300 && !found; c++) begin
            @(posedge clk);
            #1;
            rx_ready = ~rx_ready;
            for (int i = base; i < log_q.size(); i++)
                if (log_q[i].wr && log_q[i].addr == 4'hd && log_q[i].data == 32'h2)
                    found = 1'b1;
        end
        rx_ready = 1'b1;
        checkOutput("toggle_done_seen", {63'h0, found}, 64'd1);
        checkOutput("toggle_byte_count", 64'(rx_q.size() - rbase), 64'd12);
        for (int k = 0; k < 12; k++)
            checkByte(rbase + k, 8'(8'ha0 + k), k == 11, $sformatf("toggle_byte%0d", k));
        checkOutput("rx_hold_stable", 64'(stall_err), 64'd0);

        // TX 5 bytes, buffer becomes free on the third poll
        $display("[TB] TX frame of 5 bytes");
        int_flag   = 32'h0;
        free_after = a_reads + 2;
        base       = log_q.size();
        for (int k = 0; k < 5; k++)
            applyStimulus(8'(8'h11 + k), k == 4, "tx5_accept");
        waitForAccess(base, 1'b1, 4'he, 32'h2, 200, "tx5_switch_seen");
        checkOutput("tx5_log_count", 64'(log_q.size() - base), 64'd7);
        checkAccess(base,     1'b1, 4'he, 32'h0,        "tx5_clr");
        checkAccess(base + 1, 1'b1, 4'hc, 32'h14131211, "tx5_word0");
        checkAccess(base + 2, 1'b1, 4'hc, 32'h00000015, "tx5_word1");
        checkAccess(base + 3, 1'b0, 4'ha, 32'h0,        "tx5_poll0");
        checkAccess(base + 4, 1'b0, 4'ha, 32'h0,        "tx5_poll1");
        checkAccess(base + 5, 1'b0, 4'ha, 32'h20,       "tx5_poll2");
        checkAccess(base + 6, 1'b1, 4'he, 32'h2,        "tx5_switch");
        checkOutput("tx5_flag_last", {56'h0, flag_last}, 64'h20);

        // TX 300 bytes: only the first 256 reach TX RAM
        $display("[TB] TX frame of 300 bytes");
        free_after = a_reads;
        base       = log_q.size();
        obase      = ovf_cnt;
        for (int k = 0; k < 300; k++)
            applyStimulus(8'(k), k == 299, "tx300_accept");
        waitForAccess(base, 1'b1, 4'he, 32'h2, 200, "tx300_switch_seen");
        nc      = 0;
        first_w = 'x;
        last_w  = 'x;
        for (int i = base; i < log_q.size(); i++)
            if (log_q[i].wr && log_q[i].addr == 4'hc) begin
                if (nc == 0)
                    first_w = log_q[i].data;
                last_w = log_q[i].data;
                nc++;
            end
        checkOutput("tx300_word_writes", 64'(nc), 64'd64);
        checkOutput("tx300_first_word", {32'h0, first_w}, 64'h03020100);
        checkOutput("tx300_last_word", {32'h0, last_w}, 64'hfffefdfc);
        checkOutput("tx300_overflow_pulses", 64'(ovf_cnt - obase), 64'd1);
        checkAccess(base, 1'b1, 4'he, 32'h0, "tx300_clr");
        checkAccess(log_q.size() - 1, 1'b1, 4'he, 32'h2, "tx300_switch");

        // irq raised mid-frame waits until the TX page is switched
        $display("[TB] irq during TX");
        int_flag   = 32'h0002;
        rx_ram[0]  = 32'h00ccbbaa;
        free_after = a_reads;
        base       = log_q.size();
        rbase      = rx_q.size();
        applyStimulus(8'ha1, 1'b0, "mix_accept0");
        irq = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(8'ha2, 1'b1, "mix_accept1");
        waitForAccess(base, 1'b1, 4'hd, 32'h2, 200, "mix_rx_done_seen");
        irq = 1'b0;
        checkOutput("mix_log_count", 64'(log_q.size() - base), 64'd8);
        checkAccess(base,     1'b1, 4'he, 32'h0,        "mix_tx_clr");
        checkAccess(base + 1, 1'b1, 4'hc, 32'h0000a2a1, "mix_tx_word");
        checkAccess(base + 2, 1'b0, 4'ha, 32'h22,       "mix_tx_poll");
        checkAccess(base + 3, 1'b1, 4'he, 32'h2,        "mix_tx_switch");
        checkAccess(base + 4, 1'b0, 4'ha, 32'h22,       "mix_rx_flag");
        checkAccess(base + 5, 1'b1, 4'hd, 32'h0,        "mix_rx_clr");
        checkAccess(base + 6, 1'b0, 4'hb, 32'h00ccbbaa, "mix_rx_word");
        checkAccess(base + 7, 1'b1, 4'hd, 32'h2,        "mix_rx_release");
        checkByte(rbase,     8'haa, 1'b0, "mix_byte0");
        checkByte(rbase + 1, 8'hbb, 1'b0, "mix_byte1");
        checkByte(rbase + 2, 8'hcc, 1'b1, "mix_byte2");

        // Reset while stalled in RX_OUT restarts the init sequence
        $display("[TB] reset during RX output");
        int_flag   = 32'h0502;
        free_after = 1000000;
        rx_ready   = 1'b0;
        pulseIrq();
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            @(posedge clk);
            #1;
            if (rx_valid)
                found = 1'b1;
        end
        checkOutput("stall_reached", {63'h0, found}, 64'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_mid_rx", {61'h0, bus.csr_read, bus.csr_write, rx_valid}, 64'd0);
        base     = log_q.size();
        reset    = 1'b0;
        rx_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkInit(base, "reinit");
        checkOutput("reinit_rx_valid", {63'h0, rx_valid}, 64'd0);

        checkOutput("no_rd_wr_overlap", 64'(both_cnt), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
